// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku grid read-out path.
// Holds the grid geometry constants, the unloader state encoding, the
// stream beat payload layout and the cell-value integrity test.
package sudoku_pkg;

    localparam int CELLS    = 81;
    localparam int GRID_DIM = 9;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 7;
    localparam int TAG_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } unload_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  row;
        logic [TAG_W-1:0]  col;
        logic              last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // A solved cell must hold 1..9; anything else means the solve is corrupt.
    function automatic logic cell_invalid(input logic [DATA_W-1:0] value);
        return (value == '0) || (value > DATA_W'(9));
    endfunction

endpackage

// File: rtl/sudoku_out_fifo.sv
// Two-entry synchronous fifo buffering returned cell beats for the stream.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous flush (pointers and count to zero)
//   push/wr_data write one entry (caller guarantees not full)
//   pop          consume head entry (caller guarantees not empty)
//   rd_data      head entry, valid whenever count != 0
//   count        number of stored entries, 0..2
module sudoku_out_fifo #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/sudoku_grid_unloader.sv
// Streams the solved 81-cell grid out of the cell memory after the solver
// finishes, tagging each beat with its row/column and flagging cells that
// are not 1..9.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_done, i_replay           pass start (rising edge) / restart from DONE
//   o_mem_rden, o_mem_rdaddr   memory read request (data returns next cycle)
//   i_mem_rddata               memory read data
//   o_valid, i_ready           stream handshake
//   o_data, o_row, o_col, o_last  stream payload
//   o_busy, o_unload_done, o_err  status
module sudoku_grid_unloader
    import sudoku_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_done,
    input  logic              i_replay,
    output logic              o_mem_rden,
    output logic [ADDR_W-1:0] o_mem_rdaddr,
    input  logic [DATA_W-1:0] i_mem_rddata,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [TAG_W-1:0]  o_row,
    output logic [TAG_W-1:0]  o_col,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_unload_done,
    output logic              o_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [TAG_W-1:0]  LAST_COL  = TAG_W'(GRID_DIM - 1);

    unload_state_t     state_q, state_d;
    logic              i_done_q;
    logic              done_rise;
    logic              enter_run;
    logic              issue;
    logic              pop;
    logic [2:0]        occupancy;
    logic [1:0]        fifo_count;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [TAG_W-1:0]  iss_row_q;
    logic [TAG_W-1:0]  iss_col_q;
    logic              vld_p1;
    logic [TAG_W-1:0]  row_p1;
    logic [TAG_W-1:0]  col_p1;
    logic              last_p1;
    beat_t             beat_p2;
    beat_t             head;
    logic              err_q;

    assign done_rise = i_done && !i_done_q;
    assign pop       = o_valid && i_ready;

    // Entries already owed to the fifo (stored + in flight) after this
    // cycle's pop; keeping this below 2 means a return always has room.
    assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue     = (state_q == ST_RUN) && (occupancy < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            i_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done;
        end
    end

    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (done_rise) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue && (rd_addr_q == LAST_ADDR)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head.last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_replay) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- p0: read issue (address and row/col walk) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            iss_row_q <= '0;
            iss_col_q <= '0;
        end else if (enter_run) begin
            rd_addr_q <= '0;
            iss_row_q <= '0;
            iss_col_q <= '0;
        end else if (issue) begin
            // Address saturates at the last cell and holds outside RUN.
            if (rd_addr_q != LAST_ADDR) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end
            if (iss_col_q == LAST_COL) begin
                iss_col_q <= '0;
                iss_row_q <= iss_row_q + 1'b1;
            end else begin
                iss_col_q <= iss_col_q + 1'b1;
            end
        end
    end

    // ---- p1: read in flight, tags wait for the memory data ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            // enter_run and issue never coincide, so this also clears on entry.
            vld_p1 <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            row_p1  <= iss_row_q;
            col_p1  <= iss_col_q;
            last_p1 <= (rd_addr_q == LAST_ADDR);
        end
    end

    // ---- p2: returned beat enters the output fifo ----
    always_comb begin
        beat_p2      = '0;
        beat_p2.data = i_mem_rddata;
        beat_p2.row  = row_p1;
        beat_p2.col  = col_p1;
        beat_p2.last = last_p1;
    end

    sudoku_out_fifo #(
        .WIDTH (BEAT_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (enter_run),
        .push    (vld_p1),
        .wr_data (beat_p2),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (enter_run) begin
            err_q <= 1'b0;
        end else if (pop && cell_invalid(head.data)) begin
            err_q <= 1'b1;
        end
    end

    assign o_mem_rden    = issue;
    assign o_mem_rdaddr  = rd_addr_q;
    assign o_valid       = (fifo_count != 2'd0);
    assign o_data        = head.data;
    assign o_row         = head.row;
    assign o_col         = head.col;
    assign o_last        = head.last;
    assign o_busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_unload_done = (state_q == ST_DONE);
    assign o_err         = err_q;

endmodule

// File: tb/tb_sudoku_grid_unloader.sv
module tb_sudoku_grid_unloader;

    logic       clk;
    logic       rst_n;
    logic       i_done;
    logic       i_replay;
    logic       o_mem_rden;
    logic [6:0] o_mem_rdaddr;
    logic [3:0] i_mem_rddata;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_data;
    logic [3:0] o_row;
    logic [3:0] o_col;
    logic       o_last;
    logic       o_busy;
    logic       o_unload_done;
    logic       o_err;

    logic [3:0] mem [0:127];
    int         n_checks;
    int         n_fail;

    sudoku_grid_unloader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_done        (i_done),
        .i_replay      (i_replay),
        .o_mem_rden    (o_mem_rden),
        .o_mem_rdaddr  (o_mem_rdaddr),
        .i_mem_rddata  (i_mem_rddata),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_row         (o_row),
        .o_col         (o_col),
        .o_last        (o_last),
        .o_busy        (o_busy),
        .o_unload_done (o_unload_done),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell memory: one-cycle read latency.
    always @(posedge clk) begin
        if (o_mem_rden) i_mem_rddata <= mem[o_mem_rdaddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Valid solution pattern; bad=1 plants 0 at cell 40 and 12 at cell 77.
    task automatic load_grid(input bit bad);
        for (int i = 0; i < 128; i++) mem[i] = 4'd0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                mem[r*9+c] = 4'(((r*3 + r/3 + c) % 9) + 1);
        if (bad) begin
            mem[40] = 4'd0;
            mem[77] = 4'd12;
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_rden",   o_mem_rden,    0);
        chk("rst_rdaddr", o_mem_rdaddr,  0);
        chk("rst_valid",  o_valid,       0);
        chk("rst_data",   o_data,        0);
        chk("rst_row",    o_row,         0);
        chk("rst_col",    o_col,         0);
        chk("rst_last",   o_last,        0);
        chk("rst_busy",   o_busy,        0);
        chk("rst_done",   o_unload_done, 0);
        chk("rst_err",    o_err,         0);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for cycles 0..9.
    // Cycle 0 is the first RUN cycle. abort_at>0 returns once that many beats are taken.
    task automatic run_pass(input int mode, input bit inject, input int abort_at, input bit exp_err_end);
        int          idx, issued, accepted, first_cyc, last_cyc;
        bit          exp_err, stalled, finished, pop;
        logic [12:0] held, cur;
        idx = 0; issued = 0; accepted = 0; first_cyc = -1; last_cyc = -1;
        exp_err = 0; stalled = 0; finished = 0; held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (abort_at > 0 && idx >= abort_at) begin
                finished = 1;
                break;
            end
            i_replay = inject && (cyc == 10);
            if (inject && cyc == 81) i_done = 1'b0;
            if (inject && cyc == 82) i_done = 1'b1;
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = (cyc >= 10);
            endcase
            #1;
            if (cyc == 0) begin
                chk("run_busy", o_busy, 1);
                chk("run_err_clear", o_err, 0);
            end
            if (o_unload_done) begin
                chk("beats", idx, 81);
                chk("err_end", o_err, exp_err_end);
                chk("done_valid", o_valid, 0);
                if (mode == 0) begin
                    chk("first_beat_cyc", first_cyc, 2);
                    chk("last_beat_cyc", last_cyc, 82);
                    chk("done_cyc", cyc, 83);
                end
                finished = 1;
                break;
            end
            if (mode == 2 && cyc == 9) begin
                chk("stall_issues", issued, 2);
                chk("stall_valid", o_valid, 1);
                chk("stall_rden", o_mem_rden, 0);
            end
            pop = o_valid && i_ready;
            cur = {o_data, o_row, o_col, o_last};
            if (stalled) chk("stall_hold", cur, held);
            stalled = o_valid && !i_ready;
            held    = cur;
            if (o_mem_rden) begin
                chk("credit", 32'((issued - accepted - int'(pop)) < 2), 1);
                chk("rdaddr", o_mem_rdaddr, issued);
                issued++;
            end
            if (pop) begin
                if (idx <= 80) begin
                    chk("data", o_data, mem[idx]);
                    chk("row", o_row, idx / 9);
                    chk("col", o_col, idx % 9);
                    chk("last", o_last, 32'(idx == 80));
                    chk("err", o_err, exp_err);
                    if (mem[idx] == 0 || mem[idx] > 9) exp_err = 1;
                    if (first_cyc < 0) first_cyc = cyc;
                    if (idx == 80) last_cyc = cyc;
                end else begin
                    chk("extra_beat", idx, 80);
                end
                idx++;
                accepted++;
            end
        end
        if (!finished) chk("pass_timeout", 0, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        i_done   = 1'b0;
        i_replay = 1'b0;
        i_ready  = 1'b1;
        load_grid(0);
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", o_busy, 0);

        // Good grid, ready high, replay in RUN and i_done toggle in DRAIN.
        i_done = 1'b1;
        run_pass(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("done_hold", o_unload_done, 1);
        chk("done_rdaddr", o_mem_rdaddr, 80);
        chk("done_rden", o_mem_rden, 0);
        chk("done_busy", o_busy, 0);

        // Corrupt grid with random backpressure, then ready-low start.
        load_grid(1);
        @(negedge clk);
        i_replay = 1'b1;
        run_pass(1, 0, 0, 1);
        @(negedge clk);
        i_replay = 1'b1;
        run_pass(2, 0, 0, 1);

        // Abort with reset after beat 30, then a fresh pass.
        load_grid(0);
        @(negedge clk);
        i_replay = 1'b1;
        run_pass(0, 0, 31, 0);
        rst_n  = 1'b0;
        i_done = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_busy", o_busy, 0);
        @(negedge clk);
        i_done = 1'b1;
        run_pass(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
